// File: rtl/seq_mac_tile_sched.sv
// seq_mac_tile_sched: drives one seq_mult_adder MAC over an M x N output tile (m outer, n middle, kt inner).
// Latency: FETCH + ISSUE + MAC latency + 1 cycle per K-chunk; one result per (m,n) after its last chunk.
// Backpressure: mac_ready_i low holds ISSUE, res_ready_i low holds WRITE; outputs stay stable and nothing new is issued.
//
// Optional feature macro: SCHED_BIAS_EN. When it is defined, bias_addr_o (= n) and bias_i are added, and
// kt == 0 chunks take C_in from bias_i. When it is undefined, kt == 0 chunks take C_in = 0.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cfg_valid_i/cfg_ready_o      job request; the fields m/n/kt and bsa/bsb are latched on the handshake
//   rd_en_o, a_addr_o, b_addr_o  operand-buffer read strobe and addresses; data returns the next cycle
//   mac_valid_o/mac_ready_i      chunk issue with mac_c_o and the latched bitsizes mac_bsa_o/mac_bsb_o
//   mac_valid_i/mac_ready_o      MAC result mac_d_i, accepted only while waiting for it
//   res_valid_o/res_ready_i      one accumulated result per (m,n) with its coordinates
//   done_o, err_o                job-end pulse; sticky illegal-config flag
module seq_mac_tile_sched #(
   parameter int MAX_WIDTH = 16,
   parameter int P         = 2,
   parameter int MAX_M     = 16,
   parameter int MAX_N     = 16,
   parameter int MAX_KT    = 16,
   parameter int BSW       = $clog2(MAX_WIDTH/P)+2,
   localparam int MDW      = $clog2(MAX_M)+1,
   localparam int NDW      = $clog2(MAX_N)+1,
   localparam int KDW      = $clog2(MAX_KT)+1,
   localparam int MIW      = $clog2(MAX_M),
   localparam int NIW      = $clog2(MAX_N),
   localparam int KIW      = $clog2(MAX_KT),
   localparam int AAW      = $clog2(MAX_M*MAX_KT),
   localparam int BAW      = $clog2(MAX_KT*MAX_N)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           cfg_valid_i,
   output logic           cfg_ready_o,
   input  logic [MDW-1:0] cfg_m_i,
   input  logic [NDW-1:0] cfg_n_i,
   input  logic [KDW-1:0] cfg_kt_i,
   input  logic [BSW-1:0] cfg_bsa_i,
   input  logic [BSW-1:0] cfg_bsb_i,
   output logic           rd_en_o,
   output logic [AAW-1:0] a_addr_o,
   output logic [BAW-1:0] b_addr_o,
   output logic           mac_valid_o,
   input  logic           mac_ready_i,
   output logic [31:0]    mac_c_o,
   output logic [BSW-1:0] mac_bsa_o,
   output logic [BSW-1:0] mac_bsb_o,
   input  logic           mac_valid_i,
   output logic           mac_ready_o,
   input  logic [31:0]    mac_d_i,
   output logic           res_valid_o,
   input  logic           res_ready_i,
   output logic [31:0]    res_data_o,
   output logic [MIW-1:0] res_m_o,
   output logic [NIW-1:0] res_n_o,
`ifdef SCHED_BIAS_EN
   output logic [NIW-1:0] bias_addr_o,
   input  logic [31:0]    bias_i,
`endif
   output logic           done_o,
   output logic           err_o
);

   localparam int MAXBS = MAX_WIDTH / P;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_WRITE
   } state_t;

   state_t         state_q;
   logic [MDW-1:0] m_cfg_q;
   logic [NDW-1:0] n_cfg_q;
   logic [KDW-1:0] kt_cfg_q;
   logic [BSW-1:0] bsa_q, bsb_q;
   logic [MIW-1:0] m_q;
   logic [NIW-1:0] n_q;
   logic [KIW-1:0] kt_q;
   logic [AAW-1:0] a_base_q;   // m * KT, advanced by KT at each row change
   logic [AAW-1:0] a_addr_q;
   logic [BAW-1:0] b_addr_q;
   logic [31:0]    acc_q;
   logic [31:0]    c_q;
   logic           rd_en_q, mac_vld_q, mac_rdy_q, res_vld_q, done_q, err_q;
`ifdef SCHED_BIAS_EN
   logic           issue_first_q;   // first ISSUE cycle: the bias read data is live on bias_i
   logic [31:0]    bias_q;          // bias held for the rest of a stalled ISSUE
`endif

   logic cfg_ok;
   logic kt_last, n_last, m_last;

   // Range checks on the raw config fields. The fields are one bit wider than the maximum, so > MAX can occur.
   always_comb begin
      cfg_ok = 1'b1;
      if (cfg_m_i == '0 || int'(cfg_m_i) > MAX_M)     cfg_ok = 1'b0;
      if (cfg_n_i == '0 || int'(cfg_n_i) > MAX_N)     cfg_ok = 1'b0;
      if (cfg_kt_i == '0 || int'(cfg_kt_i) > MAX_KT)  cfg_ok = 1'b0;
      if (cfg_bsa_i == '0 || int'(cfg_bsa_i) > MAXBS) cfg_ok = 1'b0;
      if (cfg_bsb_i == '0 || int'(cfg_bsb_i) > MAXBS) cfg_ok = 1'b0;
   end

   assign kt_last = ({1'b0, kt_q} == (kt_cfg_q - KDW'(1)));
   assign n_last  = ({1'b0, n_q}  == (n_cfg_q  - NDW'(1)));
   assign m_last  = ({1'b0, m_q}  == (m_cfg_q  - MDW'(1)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         m_cfg_q   <= '0;
         n_cfg_q   <= '0;
         kt_cfg_q  <= '0;
         bsa_q     <= '0;
         bsb_q     <= '0;
         m_q       <= '0;
         n_q       <= '0;
         kt_q      <= '0;
         a_base_q  <= '0;
         a_addr_q  <= '0;
         b_addr_q  <= '0;
         acc_q     <= '0;
         c_q       <= '0;
         rd_en_q   <= 1'b0;
         mac_vld_q <= 1'b0;
         mac_rdy_q <= 1'b0;
         res_vld_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef SCHED_BIAS_EN
         issue_first_q <= 1'b0;
         bias_q        <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cfg_valid_i) begin
                  m_cfg_q  <= cfg_m_i;
                  n_cfg_q  <= cfg_n_i;
                  kt_cfg_q <= cfg_kt_i;
                  bsa_q    <= cfg_bsa_i;
                  bsb_q    <= cfg_bsb_i;
                  m_q      <= '0;
                  n_q      <= '0;
                  kt_q     <= '0;
                  a_base_q <= '0;
                  a_addr_q <= '0;
                  b_addr_q <= '0;
                  if (cfg_ok) begin
                     err_q   <= 1'b0;
                     rd_en_q <= 1'b1;
                     state_q <= S_FETCH;
                  end else begin
                     // Rejected job: flag it and finish immediately without touching the MAC.
                     err_q  <= 1'b1;
                     done_q <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               rd_en_q   <= 1'b0;
               mac_vld_q <= 1'b1;
               c_q       <= (kt_q == '0) ? 32'd0 : acc_q;
`ifdef SCHED_BIAS_EN
               issue_first_q <= 1'b1;
`endif
               state_q   <= S_ISSUE;
            end
            S_ISSUE: begin
`ifdef SCHED_BIAS_EN
               if (issue_first_q) begin
                  bias_q        <= bias_i;
                  issue_first_q <= 1'b0;
               end
`endif
               if (mac_ready_i) begin
                  mac_vld_q <= 1'b0;
                  mac_rdy_q <= 1'b1;
                  state_q   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mac_valid_i) begin
                  acc_q     <= mac_d_i;
                  mac_rdy_q <= 1'b0;
                  if (kt_last) begin
                     res_vld_q <= 1'b1;
                     state_q   <= S_WRITE;
                  end else begin
                     kt_q     <= kt_q + KIW'(1);
                     a_addr_q <= a_addr_q + AAW'(1);
                     b_addr_q <= b_addr_q + BAW'(n_cfg_q);
                     rd_en_q  <= 1'b1;
                     state_q  <= S_FETCH;
                  end
               end
            end
            S_WRITE: begin
               if (res_ready_i) begin
                  res_vld_q <= 1'b0;
                  kt_q      <= '0;
                  if (n_last) begin
                     n_q      <= '0;
                     b_addr_q <= '0;
                     if (m_last) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                     end else begin
                        m_q      <= m_q + MIW'(1);
                        a_base_q <= a_base_q + AAW'(kt_cfg_q);
                        a_addr_q <= a_base_q + AAW'(kt_cfg_q);
                        rd_en_q  <= 1'b1;
                        state_q  <= S_FETCH;
                     end
                  end else begin
                     // Next column of the same row: A restarts at the row base, B at column n+1.
                     n_q      <= n_q + NIW'(1);
                     a_addr_q <= a_base_q;
                     b_addr_q <= BAW'(n_q) + BAW'(1);
                     rd_en_q  <= 1'b1;
                     state_q  <= S_FETCH;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cfg_ready_o = (state_q == S_IDLE);
   assign rd_en_o     = rd_en_q;
   assign a_addr_o    = a_addr_q;
   assign b_addr_o    = b_addr_q;
   assign mac_valid_o = mac_vld_q;
   assign mac_ready_o = mac_rdy_q;
   assign mac_bsa_o   = bsa_q;
   assign mac_bsb_o   = bsb_q;
   assign res_valid_o = res_vld_q;
   assign res_data_o  = acc_q;
   assign res_m_o     = m_q;
   assign res_n_o     = n_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

`ifdef SCHED_BIAS_EN
   assign bias_addr_o = n_q;
   // The bias read returns during the first ISSUE cycle, so it is passed straight through, then held.
   assign mac_c_o = (kt_q != '0) ? c_q : (issue_first_q ? bias_i : bias_q);
`else
   assign mac_c_o = c_q;
`endif

   // The MAC may only present a result while this block is waiting for one.
   mac_valid_only_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
      mac_valid_i |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_seq_mac_tile_sched.sv
`timescale 1ns/1ps
module tb_seq_mac_tile_sched;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i;
   logic        cfg_valid_i, cfg_ready_o;
   logic [4:0]  cfg_m_i, cfg_n_i, cfg_kt_i, cfg_bsa_i, cfg_bsb_i;
   logic        rd_en_o;
   logic [7:0]  a_addr_o, b_addr_o;
   logic        mac_valid_o, mac_ready_i;
   logic [31:0] mac_c_o;
   logic [4:0]  mac_bsa_o, mac_bsb_o;
   logic        mac_valid_i, mac_ready_o;
   logic [31:0] mac_d_i;
   logic        res_valid_o, res_ready_i;
   logic [31:0] res_data_o;
   logic [3:0]  res_m_o, res_n_o;
   logic        done_o, err_o;
`ifdef SCHED_BIAS_EN
   logic [3:0]  bias_addr_o;
   logic [31:0] bias_i;
   localparam bit BIAS_ON = 1'b1;
`else
   localparam bit BIAS_ON = 1'b0;
`endif

   seq_mac_tile_sched dut (
      .clk_i(clk), .rst_i(rst_i),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_m_i(cfg_m_i), .cfg_n_i(cfg_n_i), .cfg_kt_i(cfg_kt_i),
      .cfg_bsa_i(cfg_bsa_i), .cfg_bsb_i(cfg_bsb_i),
      .rd_en_o(rd_en_o), .a_addr_o(a_addr_o), .b_addr_o(b_addr_o),
      .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i), .mac_c_o(mac_c_o),
      .mac_bsa_o(mac_bsa_o), .mac_bsb_o(mac_bsb_o),
      .mac_valid_i(mac_valid_i), .mac_ready_o(mac_ready_o), .mac_d_i(mac_d_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
      .res_m_o(res_m_o), .res_n_o(res_n_o),
`ifdef SCHED_BIAS_EN
      .bias_addr_o(bias_addr_o), .bias_i(bias_i),
`endif
      .done_o(done_o), .err_o(err_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
      end
   endtask

   // Operand buffers: each entry is a two-element chunk of signed 16-bit values.
   int a_lo[256], a_hi[256], b_lo[256], b_hi[256];
   int exp_a[$], exp_b[$], exp_c[$], exp_d[$], exp_m[$], exp_n[$];

   int  ra0, ra1, rb0, rb1;
   int  rd_cnt = 0, issue_cnt = 0, res_cnt = 0, done_cnt = 0;
   int  cur_bsa, cur_bsb;
   int  last_res;
   bit  done_prev = 0;
   bit  mac_hold = 0, res_hold = 0, macd_hold = 0;
   bit  mac_pend = 0, mac_fired = 0;
   int  mac_lat;
   int  mac_d;

   function automatic int dot(input int x0, input int x1, input int y0, input int y1);
      return x0 * y0 + x1 * y1;
   endfunction

   task automatic fill_rand();
      for (int i = 0; i < 256; i++) begin
         a_lo[i] = $urandom_range(0, 65535) - 32768;
         a_hi[i] = $urandom_range(0, 65535) - 32768;
         b_lo[i] = $urandom_range(0, 65535) - 32768;
         b_hi[i] = $urandom_range(0, 65535) - 32768;
      end
   endtask

   // Buffer, MAC and result-sink models. Inputs are decided at the falling edge for the next rising edge,
   // so a handshake seen here is the one the DUT takes at the following rising edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_i) begin
            mac_valid_i = 1'b0;
            mac_ready_i = 1'b0;
            res_ready_i = 1'b0;
            mac_pend    = 0;
            mac_fired   = 0;
            done_prev   = 0;
         end else begin
            if (done_o) begin
               chk("done_pulse", 32'(done_prev), 0);
               done_cnt++;
            end
            done_prev = done_o;

            if (rd_en_o) begin
               rd_cnt++;
               if (exp_a.size() == 0) chk("rd_extra", 32'(rd_en_o), 0);
               else begin
                  chk("a_addr", 32'(a_addr_o), exp_a.pop_front());
                  chk("b_addr", 32'(b_addr_o), exp_b.pop_front());
               end
               ra0 = a_lo[a_addr_o]; ra1 = a_hi[a_addr_o];
               rb0 = b_lo[b_addr_o]; rb1 = b_hi[b_addr_o];
`ifdef SCHED_BIAS_EN
               bias_i = 32'(100 + int'(bias_addr_o));
`endif
            end

            if (mac_fired) begin
               mac_valid_i = 1'b0;
               mac_fired   = 0;
            end
            if (mac_pend && !macd_hold) begin
               if (mac_lat > 0) mac_lat--;
               else begin
                  mac_valid_i = 1'b1;
                  mac_d_i     = mac_d;
               end
            end
            if (mac_valid_i && mac_ready_o) begin
               mac_fired = 1;
               mac_pend  = 0;
            end

            mac_ready_i = mac_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (mac_valid_o && mac_ready_i) begin
               issue_cnt++;
               if (exp_c.size() == 0) chk("issue_extra", 32'(mac_valid_o), 0);
               else chk("mac_c", mac_c_o, exp_c.pop_front());
               chk("mac_bsa", 32'(mac_bsa_o), cur_bsa);
               chk("mac_bsb", 32'(mac_bsb_o), cur_bsb);
               mac_d    = int'(mac_c_o) + dot(ra0, ra1, rb0, rb1);
               mac_lat  = $urandom_range(0, 3);
               mac_pend = 1;
            end

            res_ready_i = res_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (res_valid_o && res_ready_i) begin
               res_cnt++;
               last_res = int'(res_data_o);
               if (exp_d.size() == 0) chk("res_extra", 32'(res_valid_o), 0);
               else begin
                  chk("res_data", res_data_o, exp_d.pop_front());
                  chk("res_m", 32'(res_m_o), exp_m.pop_front());
                  chk("res_n", 32'(res_n_o), exp_n.pop_front());
               end
            end
         end
      end
   end

   int  job_m, job_n, job_kt;
   bit  job_legal;
   int  job_d0, job_i0, job_r0, job_s0;

   task automatic start_job(input int m, input int n, input int kt, input int bsa, input int bsb);
      int acc;
      job_m = m; job_n = n; job_kt = kt;
      job_legal = (m >= 1 && m <= 16 && n >= 1 && n <= 16 && kt >= 1 && kt <= 16 &&
                   bsa >= 1 && bsa <= 8 && bsb >= 1 && bsb <= 8);
      if (job_legal) begin
         for (int mi = 0; mi < m; mi++) begin
            for (int ni = 0; ni < n; ni++) begin
               acc = BIAS_ON ? 100 + ni : 0;
               for (int ki = 0; ki < kt; ki++) begin
                  exp_a.push_back(mi * kt + ki);
                  exp_b.push_back(ki * n + ni);
                  exp_c.push_back(acc);
                  acc = acc + dot(a_lo[mi*kt+ki], a_hi[mi*kt+ki], b_lo[ki*n+ni], b_hi[ki*n+ni]);
               end
               exp_d.push_back(acc);
               exp_m.push_back(mi);
               exp_n.push_back(ni);
            end
         end
      end
      @(negedge clk);
      job_d0 = done_cnt; job_i0 = issue_cnt; job_r0 = rd_cnt; job_s0 = res_cnt;
      cur_bsa = bsa; cur_bsb = bsb;
      cfg_m_i = 5'(m); cfg_n_i = 5'(n); cfg_kt_i = 5'(kt);
      cfg_bsa_i = 5'(bsa); cfg_bsb_i = 5'(bsb);
      cfg_valid_i = 1'b1;
      chk("cfg_ready", 32'(cfg_ready_o), 1);
      @(negedge clk);
      cfg_valid_i = 1'b0;
      chk("err_after_cfg", 32'(err_o), 32'(!job_legal));
   endtask

   task automatic finish_job();
      int budget;
      budget = job_legal ? job_m * job_n * job_kt * 40 + 100 : 10;
      for (int k = 0; k < budget && done_cnt == job_d0; k++) @(negedge clk);
      chk("done_count", done_cnt - job_d0, 1);
      chk("issue_count", issue_cnt - job_i0, job_legal ? job_m * job_n * job_kt : 0);
      chk("rd_count", rd_cnt - job_r0, job_legal ? job_m * job_n * job_kt : 0);
      chk("res_count", res_cnt - job_s0, job_legal ? job_m * job_n : 0);
      chk("model_drained", exp_a.size() + exp_c.size() + exp_d.size(), 0);
      @(negedge clk);
      chk("idle_ready", 32'(cfg_ready_o), 1);
   endtask

   task automatic run_job(input int m, input int n, input int kt, input int bsa, input int bsb);
      start_job(m, n, kt, bsa, bsb);
      finish_job();
   endtask

   initial begin
      int c0, i0, r0, d0, s0, dv, mv, nv;
      rst_i = 1'b1;
      cfg_valid_i = 1'b0;
      cfg_m_i = '0; cfg_n_i = '0; cfg_kt_i = '0; cfg_bsa_i = '0; cfg_bsb_i = '0;
      mac_ready_i = 1'b0; mac_valid_i = 1'b0; mac_d_i = '0; res_ready_i = 1'b0;
`ifdef SCHED_BIAS_EN
      bias_i = '0;
`endif
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("rst_cfg_ready", 32'(cfg_ready_o), 1);
      chk("rst_rd_en", 32'(rd_en_o), 0);
      chk("rst_mac_valid", 32'(mac_valid_o), 0);
      chk("rst_mac_ready", 32'(mac_ready_o), 0);
      chk("rst_res_valid", 32'(res_valid_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_err", 32'(err_o), 0);

      // Single output, single chunk: 3*5 + 4*(-2) = 7 (plus bias 100 when enabled).
      fill_rand();
      a_lo[0] = 3; a_hi[0] = 4; b_lo[0] = 5; b_hi[0] = -2;
      run_job(1, 1, 1, 8, 8);
      chk("t1_result", 32'(last_res), BIAS_ON ? 107 : 7);

      // 2x3 tile, two chunks per output: ordering, chained C_in and address walk.
      fill_rand();
      run_job(2, 3, 2, 8, 8);

      // Result backpressure held for 20 cycles.
      fill_rand();
      res_hold = 1;
      start_job(2, 2, 1, 4, 6);
      for (int k = 0; k < 200 && !res_valid_o; k++) @(negedge clk);
      chk("t3_res_seen", 32'(res_valid_o), 1);
      dv = int'(res_data_o); mv = int'(res_m_o); nv = int'(res_n_o);
      r0 = rd_cnt; i0 = issue_cnt;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("t3_valid_hold", 32'(res_valid_o), 1);
         chk("t3_data_hold", res_data_o, dv);
         chk("t3_m_hold", 32'(res_m_o), mv);
         chk("t3_n_hold", 32'(res_n_o), nv);
      end
      chk("t3_no_new_rd", rd_cnt - r0, 0);
      chk("t3_no_new_issue", issue_cnt - i0, 0);
      res_hold = 0;
      finish_job();

      // Issue backpressure held for 5 cycles.
      fill_rand();
      mac_hold = 1;
      start_job(1, 1, 2, 7, 3);
      for (int k = 0; k < 50 && !mac_valid_o; k++) @(negedge clk);
      chk("t4_issue_seen", 32'(mac_valid_o), 1);
      c0 = int'(mac_c_o); i0 = issue_cnt;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t4_valid_hold", 32'(mac_valid_o), 1);
         chk("t4_c_hold", mac_c_o, c0);
         chk("t4_bsa_hold", 32'(mac_bsa_o), 7);
         chk("t4_bsb_hold", 32'(mac_bsb_o), 3);
      end
      chk("t4_no_issue", issue_cnt - i0, 0);
      mac_hold = 0;
      finish_job();

      // Illegal configurations, then a legal one that clears err_o.
      run_job(1, 1, 0, 8, 8);
      chk("t5_err_kt0", 32'(err_o), 1);
      run_job(1, 1, 1, 9, 8);
      chk("t5_err_bsa9", 32'(err_o), 1);
      run_job(17, 1, 1, 8, 8);
      chk("t5_err_m17", 32'(err_o), 1);
      fill_rand();
      run_job(1, 2, 1, 8, 8);
      chk("t5_err_cleared", 32'(err_o), 0);

      // Reset while waiting for a MAC result.
      fill_rand();
      macd_hold = 1;
      start_job(2, 2, 2, 8, 8);
      for (int k = 0; k < 50 && !mac_ready_o; k++) @(negedge clk);
      chk("t6_in_wait", 32'(mac_ready_o), 1);
      @(posedge clk);
      #1 rst_i = 1'b1;
      exp_a.delete(); exp_b.delete(); exp_c.delete();
      exp_d.delete(); exp_m.delete(); exp_n.delete();
      macd_hold = 0;
      @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("t6_cfg_ready", 32'(cfg_ready_o), 1);
      chk("t6_mac_ready", 32'(mac_ready_o), 0);
      chk("t6_res_valid", 32'(res_valid_o), 0);
      chk("t6_err", 32'(err_o), 0);
      d0 = done_cnt; s0 = res_cnt;
      repeat (10) @(negedge clk);
      chk("t6_no_done", done_cnt - d0, 0);
      chk("t6_no_res", res_cnt - s0, 0);
      fill_rand();
      run_job(2, 2, 2, 8, 8);

      // Random tiles, then the address-range corners.
      for (int j = 0; j < 6; j++) begin
         fill_rand();
         run_job($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
                 $urandom_range(1, 8), $urandom_range(1, 8));
      end
      fill_rand();
      run_job(16, 1, 16, 8, 8);
      fill_rand();
      run_job(1, 16, 16, 1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/seq_mac_tile_sched.md
Name: seq_mac_tile_sched

Overview:
Tile scheduler that sequences a single seq_mult_adder datapath over an M x N output tile with KT K-chunks per output. Loop order: m outer, n middle, kt inner. It generates A/B operand-buffer read addresses, issues each chunk to the MAC with the correct C_in (chained accumulation), collects D, and emits one result per (m,n) on a valid/ready output stream.

Parameters:
MAX_WIDTH, 16, max operand width in bits (matches MAC)
P, 2, MAC digit width; bitsize fields count P-bit digits
MAX_M, 16, max rows per tile
MAX_N, 16, max columns per tile
MAX_KT, 16, max K-chunks per output
BSW, $clog2(MAX_WIDTH/P)+2, bitsize field width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cfg_valid_i  in  1  job request
cfg_ready_o  out  1  high only in IDLE
cfg_m_i / cfg_n_i / cfg_kt_i  in  $clog2(MAX_*)+1 each  tile dims (1..MAX_*)
cfg_bsa_i / cfg_bsb_i  in  BSW  A/B bitsize in digits (1..MAX_WIDTH/P)
rd_en_o  out  1  operand-buffer read strobe; data returns next cycle
a_addr_o  out  $clog2(MAX_M*MAX_KT)  = m*KT + kt
b_addr_o  out  $clog2(MAX_KT*MAX_N)  = kt*N + n
mac_valid_o / mac_ready_i  out/in  1  issue handshake (MAC valid_in/ready_in)
mac_c_o  out  32  C_in for the issued chunk
mac_bsa_o / mac_bsb_o  out  BSW  latched bitsizes, stable for the whole job
mac_valid_i / mac_ready_o  in/out  1  result handshake (MAC valid_out/ready_out)
mac_d_i  in  32  MAC D
res_valid_o / res_ready_i  out/in  1  result stream
res_data_o  out  32  accumulated output
res_m_o / res_n_o  out  index widths  output coordinates
done_o  out  1  one-cycle pulse at job end
err_o  out  1  sticky; set on illegal config, cleared by next accepted cfg

Behaviour:
- Reset: state IDLE; all counters/address bases 0; acc 0; rd_en_o, mac_valid_o, mac_ready_o, res_valid_o, done_o, err_o = 0; cfg_ready_o = 1 after reset release.
- Config: cfg_valid_i & cfg_ready_o latches all cfg fields; err_o cleared.
  - Any dim = 0, any dim > MAX, or bitsize 0 / > MAX_WIDTH/P: set err_o, pulse done_o next cycle, return to IDLE, issue nothing.
- FSM: IDLE -> FETCH -> ISSUE -> WAIT -> (FETCH | WRITE) -> ... -> IDLE.
  - FETCH: rd_en_o = 1 for exactly one cycle with current addresses.
  - ISSUE: mac_valid_o = 1; mac_c_o = 0 if kt == 0, else acc. Hold all outputs stable until mac_ready_i; then go to WAIT.
  - WAIT: mac_ready_o = 1. On mac_valid_i, acc <= mac_d_i. If kt == KT-1, go to WRITE; else kt++, a_addr += 1, b_addr += N, go to FETCH.
  - WRITE: res_valid_o = 1 with acc, m, n; hold stable until res_ready_i.
  - On the WRITE handshake: kt = 0; n++ (wrap to 0 with m++); addresses rebased from running bases (no multipliers).
  - After the last (M-1, N-1) handshake: done_o pulses one cycle, go to IDLE.
- MAC operands (row/column) come directly from the buffer, not through this block. The bench models 1-cycle read latency.
- mac_ready_o is low outside WAIT; a mac_valid_i outside WAIT is ignored (protocol violation, asserted in sim).
- Arithmetic: acc is 32-bit two's complement, wraps silently; no saturation.
- Minimum spacing between issues: FETCH + ISSUE + MAC latency + 1 cycle.
- Reset mid-job: synchronous abort to IDLE. No res/done pulse; partial acc discarded.
- cfg_valid_i while busy: ignored (cfg_ready_o = 0).

Optional Feature:
SCHED_BIAS_EN:
- Defined: adds bias_addr_o ($clog2(MAX_N), = n) and bias_i (32). bias_i is sampled in the cycle after FETCH. For kt == 0, mac_c_o = bias_i.
- Undefined: ports absent; kt == 0 issues C_in = 0.

Test Plan:
1. M=1, N=1, KT=1, bsa=bsb=8, row=[3,4], col=[5,-2] -> one result D=7 at (0,0); done_o one pulse; exactly one mac issue.
2. M=2, N=3, KT=2, 8-digit operands -> six results in order (0,0),(0,1),(0,2),(1,0)...; kt=1 issues carry prior D as C_in; a_addr sequence 0,1,0,1,0,1,2,3...; b_addr 0,3,1,4,2,5...
3. res_ready_i held low 20 cycles during WRITE -> res_valid_o/data/m/n stable; no new rd_en_o or mac_valid_o issued.
4. mac_ready_i low 5 cycles in ISSUE -> mac_valid_o, mac_c_o, bitsizes stable; single issue on the handshake.
5. cfg_kt_i=0 or cfg_bsa_i=9 (MAX_WIDTH=16, P=2) -> err_o=1, done_o pulse, zero issues; next valid cfg clears err_o.
6. rst_i asserted in WAIT of a 2x2 job -> next cycle IDLE, cfg_ready_o=1, no res_valid_o/done_o; new job completes correctly. With SCHED_BIAS_EN, bias_i=100 gives D=107 in scenario 1.
